blk_3e7762: RTL and testbench



---
 rtl/blk_3e7762_pkg.sv | 18 +
 rtl/blk_3e7762_chunk_sub.sv | 30 +++
 rtl/blk_3e7762.sv | 150 +++++++++++++++
 tb/tb_blk_3e7762.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/blk_3e7762_pkg.sv
// Shared definitions for the chunk-serial subtractor: state encodings and sizing helpers.
package blk_3e7762_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of chunk cycles per operation.
    function automatic int unsigned calc_k(input int unsigned n, input int unsigned chunk);
        return n / chunk;
    endfunction

    // Chunk index width; never narrower than one bit so K==1 still has a register.
    function automatic int unsigned idx_width(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/blk_3e7762_chunk_sub.sv
// One CHUNK-wide subtract (or add, under DL_SERIAL_ADD_MODE_EN) slice with borrow/carry in and out.
module bm_DL_chunk_subtractor #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
`ifdef DL_SERIAL_ADD_MODE_EN
    input  logic         add,
`endif
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] res;

    // The extra MSB of the W+1 bit result is the borrow (or carry in add mode).
    always_comb begin
        res = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
`ifdef DL_SERIAL_ADD_MODE_EN
        if (add) begin
            res = {1'b0, a} + {1'b0, b} + (W+1)'(bin);
        end
`endif
    end

    assign d    = res[W-1:0];
    assign bout = res[W];

endmodule

// File: rtl/blk_3e7762.sv
// Chunk-serial N-bit subtractor D = X - Y - borrowin with start/busy/done handshake.
// Optional add mode (add_nsub port) is enabled by defining DL_SERIAL_ADD_MODE_EN.
module blk_3e7762
    import blk_3e7762_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         borrowin,
`ifdef DL_SERIAL_ADD_MODE_EN
    input  logic         add_nsub,
`endif
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         borrowout,
    output logic         overflow
);

    localparam int unsigned K  = calc_k(N, CHUNK);
    localparam int unsigned IW = idx_width(K);

    logic [1:0]                 state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [K-1:0][CHUNK-1:0]    xl_q, xl_d;
    logic [K-1:0][CHUNK-1:0]    yl_q, yl_d;
    logic [K-1:0][CHUNK-1:0]    d_q, d_d;
    logic                       bor_q, bor_d;
    logic                       borrowout_q, borrowout_d;
    logic                       overflow_q, overflow_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
`ifdef DL_SERIAL_ADD_MODE_EN
    logic                       add_q, add_d;
`endif

    logic [CHUNK-1:0]           chunk_diff;
    logic                       chunk_bout;
    logic                       x_msb, y_msb;

    bm_DL_chunk_subtractor #(.W(CHUNK)) u_chunk (
        .a    (xl_q[idx_q]),
        .b    (yl_q[idx_q]),
        .bin  (bor_q),
`ifdef DL_SERIAL_ADD_MODE_EN
        .add  (add_q),
`endif
        .d    (chunk_diff),
        .bout (chunk_bout)
    );

    assign x_msb = xl_q[K-1][CHUNK-1];
    assign y_msb = yl_q[K-1][CHUNK-1];

    // Next-state and datapath update; bor_q carries borrowin into chunk 0, then the chunk borrow.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        xl_d        = xl_q;
        yl_d        = yl_q;
        d_d         = d_q;
        bor_d       = bor_q;
        borrowout_d = borrowout_q;
        overflow_d  = overflow_q;
`ifdef DL_SERIAL_ADD_MODE_EN
        add_d       = add_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    xl_d    = X;
                    yl_d    = Y;
                    bor_d   = borrowin;
`ifdef DL_SERIAL_ADD_MODE_EN
                    add_d   = add_nsub;
`endif
                    d_d     = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                d_d[idx_q] = chunk_diff;
                bor_d      = chunk_bout;
                if (idx_q == IW'(K - 1)) begin
                    idx_d       = '0;
                    borrowout_d = chunk_bout;
                    overflow_d  = (x_msb != y_msb) && (chunk_diff[CHUNK-1] != x_msb);
`ifdef DL_SERIAL_ADD_MODE_EN
                    if (add_q) begin
                        overflow_d = (x_msb == y_msb) && (chunk_diff[CHUNK-1] != x_msb);
                    end
`endif
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            xl_q        <= '0;
            yl_q        <= '0;
            d_q         <= '0;
            bor_q       <= 1'b0;
            borrowout_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DL_SERIAL_ADD_MODE_EN
            add_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xl_q        <= xl_d;
            yl_q        <= yl_d;
            d_q         <= d_d;
            bor_q       <= bor_d;
            borrowout_q <= borrowout_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DL_SERIAL_ADD_MODE_EN
            add_q       <= add_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign D         = d_q;
    assign borrowout = borrowout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_blk_3e7762.sv
// Self-checking bench for blk_3e7762 against a whole-word arithmetic reference model.
module tb_blk_3e7762;

    localparam int unsigned N     = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned K     = N / CHUNK;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          borrowin;
    logic [N-1:0]  X, Y;
    logic          busy, done, borrowout, overflow;
    logic [N-1:0]  D;
`ifdef DL_SERIAL_ADD_MODE_EN
    logic          add_nsub;
`endif

    int errors = 0;
    int checks = 0;

    blk_3e7762 #(.N(N), .CHUNK(CHUNK)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .borrowin  (borrowin),
`ifdef DL_SERIAL_ADD_MODE_EN
        .add_nsub  (add_nsub),
`endif
        .X         (X),
        .Y         (Y),
        .busy      (busy),
        .done      (done),
        .D         (D),
        .borrowout (borrowout),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic, borrow/carry is bit N of the N+1 bit result.
    task automatic model(input logic [N-1:0] x, input logic [N-1:0] y, input logic b, input logic add,
                         output logic [N-1:0] d, output logic bo, output logic ov);
        logic [N:0] r;
        if (add) r = {1'b0, x} + {1'b0, y} + (N+1)'(b);
        else     r = {1'b0, x} - {1'b0, y} - (N+1)'(b);
        d  = r[N-1:0];
        bo = r[N];
        if (add) ov = (x[N-1] == y[N-1]) && (d[N-1] != x[N-1]);
        else     ov = (x[N-1] != y[N-1]) && (d[N-1] != x[N-1]);
    endtask

    logic [N-1:0] exp_d;
    logic         exp_bo, exp_ov;

    // Called at a negedge: presents an operation and pulses start over one rising edge.
    task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic b, input logic add);
        X = x; Y = y; borrowin = b; start = 1'b1;
`ifdef DL_SERIAL_ADD_MODE_EN
        add_nsub = add;
`endif
        model(x, y, b, add, exp_d, exp_bo, exp_ov);
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("no_done_after_start", 64'(done), 64'd0);
    endtask

    // Waits (bounded) for done while scrambling the operand inputs, then checks results.
    task automatic wait_done(input string tag);
        int lat = 0;
        while (!done && lat < 20) begin
            X = $urandom; Y = $urandom; borrowin = 1'($urandom);
`ifdef DL_SERIAL_ADD_MODE_EN
            add_nsub = 1'($urandom);
`endif
            @(negedge clock);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(K));
        chk({tag, "_D"}, 64'(D), 64'(exp_d));
        chk({tag, "_borrowout"}, 64'(borrowout), 64'(exp_bo));
        chk({tag, "_overflow"}, 64'(overflow), 64'(exp_ov));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    // One idle cycle after done: the pulse ends and results hold.
    task automatic after_done(input string tag);
        @(negedge clock);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_D_hold"}, 64'(D), 64'(exp_d));
        chk({tag, "_bo_hold"}, 64'(borrowout), 64'(exp_bo));
    endtask

    task automatic do_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic b, input logic add);
        launch(x, y, b, add);
        wait_done(tag);
        after_done(tag);
    endtask

    initial begin
        int done_seen;
        reset = 1'b1; start = 1'b0; borrowin = 1'b0; X = '0; Y = '0;
`ifdef DL_SERIAL_ADD_MODE_EN
        add_nsub = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_D", 64'(D), 64'd0);
        chk("reset_bo", 64'(borrowout), 64'd0);
        chk("reset_ov", 64'(overflow), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        do_op("basic", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        chk("basic_D_const", 64'(D), 64'h2);
        do_op("ripple", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        chk("ripple_D_const", 64'(D), 64'hFFFF_FFFF);
        chk("ripple_bo_const", 64'(borrowout), 64'd1);
        do_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
        chk("ovf_neg_ov_const", 64'(overflow), 64'd1);
        do_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("ovf_pos_D_const", 64'(D), 64'h8000_0000);
        do_op("max_bin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Back-to-back: new start accepted in the DONE cycle.
        launch(32'h1234_5678, 32'h0000_0078, 1'b0, 1'b0);
        wait_done("b2b_first");
        launch(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b0);
        wait_done("b2b_second");
        chk("b2b_D_const", 64'(D), 64'hFFFF_FFFF);
        chk("b2b_bo_const", 64'(borrowout), 64'd1);
        after_done("b2b_second");

        // Reset two cycles into RUN aborts the operation silently.
        launch(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_D", 64'(D), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        chk("abort_idle_D", 64'(D), 64'd0);
        chk("abort_idle_bo", 64'(borrowout), 64'd0);
        chk("abort_idle_ov", 64'(overflow), 64'd0);
        do_op("post_abort", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);

`ifdef DL_SERIAL_ADD_MODE_EN
        do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        chk("add_wrap_D_const", 64'(D), 64'd0);
        chk("add_wrap_co_const", 64'(borrowout), 64'd1);
        do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        chk("add_ovf_ov_const", 64'(overflow), 64'd1);
`endif

        // Randomized operations, some chained back-to-back.
        for (int i = 0; i < 24; i++) begin
            logic add;
            add = 1'b0;
`ifdef DL_SERIAL_ADD_MODE_EN
            add = 1'($urandom);
`endif
            launch($urandom, $urandom, 1'($urandom), add);
            wait_done("rand");
            if ($urandom_range(1) == 0) after_done("rand");
        end
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
